alu_op_issuer: RTL and testbench

// - Sequential initiator for the combinational ALU: accepts operation requests by valid/ready,

---
 rtl/alu_op_issuer.sv | 213 +++++++++++++++++++++
 tb/tb_alu_op_issuer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//
// Sequential front end for the combinational ALU. It takes one operation
// request at a time through a valid/ready handshake and drives the operands and
// opcode onto the ALU for one cycle. It then captures the ALU result and flags
// and offers them back through a second valid/ready handshake.
//
// Illegal opcodes never reach the ALU. They answer with Error=1 and a zeroed
// result and zeroed flags.
//
// State sequence:
//   legal opcode:   IDLE -> EXEC -> RESP -> IDLE
//   illegal opcode: IDLE -> RESP -> IDLE
//
// Optional feature:
//   Define ALU_ISSUER_OVERFLOW_EN to add the output_Overflow port. It reports
//   signed overflow for add and sub and is registered together with the flags.
//
// Ports:
//   input_CLK         clock, rising edge
//   input_Reset       asynchronous active-high reset
//   input_ReqValid    request valid
//   output_ReqReady   request ready (high only in IDLE)
//   input_Opcode      requested ALUOp
//   input_OperandA/B  request operands
//   output_ALU_A/B    operands driven to the ALU
//   output_ALUOp      opcode driven to the ALU (IDLE_ALUOP when no op in flight)
//   input_ALUResult   ALU result
//   input_Zero        ALU zero flag
//   input_Negative    ALU negative flag
//   output_RespValid  response valid
//   input_RespReady   response ready
//   output_Result     captured result
//   output_Flags      captured {Z,N,C}
//   output_Error      1 = illegal opcode (result and flags are 0)
//   output_Busy       1 whenever the state is not IDLE
//   output_Overflow   signed overflow (present only with ALU_ISSUER_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int          DATA_WIDTH = 16,
    parameter logic [3:0]  IDLE_ALUOP = 4'b1100
) (
    input  logic                  input_CLK,
    input  logic                  input_Reset,
    input  logic                  input_ReqValid,
    output logic                  output_ReqReady,
    input  logic [3:0]            input_Opcode,
    input  logic [DATA_WIDTH-1:0] input_OperandA,
    input  logic [DATA_WIDTH-1:0] input_OperandB,
    output logic [DATA_WIDTH-1:0] output_ALU_A,
    output logic [DATA_WIDTH-1:0] output_ALU_B,
    output logic [3:0]            output_ALUOp,
    input  logic [DATA_WIDTH-1:0] input_ALUResult,
    input  logic                  input_Zero,
    input  logic                  input_Negative,
    output logic                  output_RespValid,
    input  logic                  input_RespReady,
    output logic [DATA_WIDTH-1:0] output_Result,
    output logic [2:0]            output_Flags,
    output logic                  output_Error,
    output logic                  output_Busy
`ifdef ALU_ISSUER_OVERFLOW_EN
    ,
    output logic                  output_Overflow
`endif
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] alu_a_reg, alu_b_reg;
    logic [3:0]            alu_op_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic [2:0]            flags_reg;
    logic                  error_reg;

    logic                  accept;
    logic                  opcode_legal;
    logic [DATA_WIDTH:0]   sum_ext;
    logic                  carry_next;

    // Legal codes are 0000..1001 plus 1100 (pass-B).
    assign opcode_legal = (input_Opcode <= 4'b1001) || (input_Opcode == 4'b1100);
    assign accept       = input_ReqValid && (state_reg == ST_IDLE);

    // Carry comes from the operands we drove, not from the ALU. This keeps
    // the flag independent of how the ALU reports carry.
    assign sum_ext = {1'b0, alu_a_reg} + {1'b0, alu_b_reg};

    always_comb begin
        carry_next = 1'b0;
        case (alu_op_reg)
            OP_ADD:  carry_next = sum_ext[DATA_WIDTH];
            OP_SUB:  carry_next = (alu_a_reg < alu_b_reg);
            default: carry_next = 1'b0;
        endcase
    end

`ifdef ALU_ISSUER_OVERFLOW_EN
    logic overflow_reg;
    logic overflow_next;
    localparam int MSB = DATA_WIDTH - 1;

    always_comb begin
        overflow_next = 1'b0;
        case (alu_op_reg)
            OP_ADD:  overflow_next = (alu_a_reg[MSB] == alu_b_reg[MSB]) &&
                                     (input_ALUResult[MSB] != alu_a_reg[MSB]);
            OP_SUB:  overflow_next = (alu_a_reg[MSB] != alu_b_reg[MSB]) &&
                                     (input_ALUResult[MSB] != alu_a_reg[MSB]);
            default: overflow_next = 1'b0;
        endcase
    end

    assign output_Overflow = overflow_reg;
`endif

    // State register
    always_ff @(posedge input_CLK or posedge input_Reset) begin
        if (input_Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = opcode_legal ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: begin
                if (input_RespReady) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath registers. Response fields change only on the accept edge for
    // an illegal opcode, or at the end of EXEC. This keeps them stable for the
    // whole RESP phase.
    always_ff @(posedge input_CLK or posedge input_Reset) begin
        if (input_Reset) begin
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= IDLE_ALUOP;
            result_reg   <= '0;
            flags_reg    <= '0;
            error_reg    <= 1'b0;
`ifdef ALU_ISSUER_OVERFLOW_EN
            overflow_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (opcode_legal) begin
                            alu_a_reg  <= input_OperandA;
                            alu_b_reg  <= input_OperandB;
                            alu_op_reg <= input_Opcode;
                        end else begin
                            // ALU outputs stay parked on the idle opcode.
                            result_reg   <= '0;
                            flags_reg    <= '0;
                            error_reg    <= 1'b1;
`ifdef ALU_ISSUER_OVERFLOW_EN
                            overflow_reg <= 1'b0;
`endif
                        end
                    end
                end
                ST_EXEC: begin
                    result_reg   <= input_ALUResult;
                    flags_reg    <= {input_Zero, input_Negative, carry_next};
                    error_reg    <= 1'b0;
`ifdef ALU_ISSUER_OVERFLOW_EN
                    overflow_reg <= overflow_next;
`endif
                    alu_a_reg    <= '0;
                    alu_b_reg    <= '0;
                    alu_op_reg   <= IDLE_ALUOP;
                end
                default: ;
            endcase
        end
    end

    assign output_ReqReady  = (state_reg == ST_IDLE);
    assign output_RespValid = (state_reg == ST_RESP);
    assign output_Busy      = (state_reg != ST_IDLE);
    assign output_ALU_A     = alu_a_reg;
    assign output_ALU_B     = alu_b_reg;
    assign output_ALUOp     = alu_op_reg;
    assign output_Result    = result_reg;
    assign output_Flags     = flags_reg;
    assign output_Error     = error_reg;

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// Testbench for alu_op_issuer.
//
// A small behavioural ALU answers the DUT's ALU outputs. It uses this opcode
// map: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 1100 pass-B.
//
// The bench runs a table of directed vectors with hand-computed expected values.
// Hand-written sequences then cover response backpressure and reset during EXEC.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_op_issuer;

    logic        clk;
    logic        input_Reset;
    logic        input_ReqValid;
    logic        output_ReqReady;
    logic [3:0]  input_Opcode;
    logic [15:0] input_OperandA;
    logic [15:0] input_OperandB;
    logic [15:0] output_ALU_A;
    logic [15:0] output_ALU_B;
    logic [3:0]  output_ALUOp;
    logic [15:0] input_ALUResult;
    logic        input_Zero;
    logic        input_Negative;
    logic        output_RespValid;
    logic        input_RespReady;
    logic [15:0] output_Result;
    logic [2:0]  output_Flags;
    logic        output_Error;
    logic        output_Busy;
`ifdef ALU_ISSUER_OVERFLOW_EN
    logic        output_Overflow;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_op_issuer dut (
        .input_CLK        (clk),
        .input_Reset      (input_Reset),
        .input_ReqValid   (input_ReqValid),
        .output_ReqReady  (output_ReqReady),
        .input_Opcode     (input_Opcode),
        .input_OperandA   (input_OperandA),
        .input_OperandB   (input_OperandB),
        .output_ALU_A     (output_ALU_A),
        .output_ALU_B     (output_ALU_B),
        .output_ALUOp     (output_ALUOp),
        .input_ALUResult  (input_ALUResult),
        .input_Zero       (input_Zero),
        .input_Negative   (input_Negative),
        .output_RespValid (output_RespValid),
        .input_RespReady  (input_RespReady),
        .output_Result    (output_Result),
        .output_Flags     (output_Flags),
        .output_Error     (output_Error),
        .output_Busy      (output_Busy)
`ifdef ALU_ISSUER_OVERFLOW_EN
        ,
        .output_Overflow  (output_Overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU model
    always_comb begin
        input_ALUResult = 16'h0000;
        case (output_ALUOp)
            4'b0000: input_ALUResult = output_ALU_A + output_ALU_B;
            4'b0001: input_ALUResult = output_ALU_A - output_ALU_B;
            4'b0010: input_ALUResult = output_ALU_A & output_ALU_B;
            4'b0011: input_ALUResult = output_ALU_A | output_ALU_B;
            4'b0100: input_ALUResult = output_ALU_A ^ output_ALU_B;
            4'b1100: input_ALUResult = output_ALU_B;
            default: input_ALUResult = 16'h0000;
        endcase
        input_Zero     = (input_ALUResult == 16'h0000);
        input_Negative = input_ALUResult[15];
    end

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flags;
        logic        err;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call one cycle after a rising edge with the DUT in IDLE and RespReady=1.
    // The task returns at the same phase, with the DUT back in IDLE.
    task automatic run_vec(input vec_t v);
        int lat;
        input_Opcode   = v.op;
        input_OperandA = v.a;
        input_OperandB = v.b;
        input_ReqValid = 1'b1;
        @(posedge clk); #1;
        input_ReqValid = 1'b0;
        input_OperandA = 16'hDEAD;     // fields must only be sampled at accept
        input_OperandB = 16'hBEEF;
        check("aluop_after_accept", 32'(output_ALUOp), 32'(v.err ? 4'b1100 : v.op));
        lat = 1;
        while (!output_RespValid && lat < 8) begin
            if (output_ALUOp !== (v.err ? 4'b1100 : v.op))
                check("aluop_exec", 32'(output_ALUOp), 32'(v.op));
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), v.err ? 32'd1 : 32'd2);
        check("result", 32'(output_Result), 32'(v.res));
        check("flags", 32'(output_Flags), 32'(v.flags));
        check("error", 32'(output_Error), 32'(v.err));
        check("aluop_in_resp", 32'(output_ALUOp), 32'h000C);
`ifdef ALU_ISSUER_OVERFLOW_EN
        check("overflow", 32'(output_Overflow), 32'(v.ovf));
`endif
        $display("op=%b a=%h b=%h -> result=%h flags=%b err=%b latency=%0d",
                 v.op, v.a, v.b, output_Result, output_Flags, output_Error, lat);
        @(posedge clk); #1;
        check("idle_after_resp", {30'd0, output_ReqReady, output_RespValid}, 32'b10);
    endtask

    initial begin
        int stable_ok;
        logic [15:0] held_result;

        //            op       a        b        res      flags   err   ovf
        vecs[0]  = '{4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 3'b010, 1'b0, 1'b1};
        vecs[1]  = '{4'b0001, 16'h0005, 16'h0005, 16'h0000, 3'b100, 1'b0, 1'b0};
        vecs[2]  = '{4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 3'b011, 1'b0, 1'b0};
        vecs[3]  = '{4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 3'b101, 1'b0, 1'b0};
        vecs[4]  = '{4'b0011, 16'h00F0, 16'h000F, 16'h00FF, 3'b000, 1'b0, 1'b0};
        vecs[5]  = '{4'b1010, 16'h1234, 16'h5678, 16'h0000, 3'b000, 1'b1, 1'b0};
        vecs[6]  = '{4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 3'b000, 1'b0, 1'b1};
        vecs[7]  = '{4'b0010, 16'h00F0, 16'h000F, 16'h0000, 3'b100, 1'b0, 1'b0};
        vecs[8]  = '{4'b1100, 16'h1234, 16'h8001, 16'h8001, 3'b010, 1'b0, 1'b0};
        vecs[9]  = '{4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b000, 1'b1, 1'b0};
        vecs[10] = '{4'b0100, 16'hAAAA, 16'h5555, 16'hFFFF, 3'b010, 1'b0, 1'b0};

        input_Reset     = 1'b1;
        input_ReqValid  = 1'b0;
        input_Opcode    = 4'b0000;
        input_OperandA  = 16'h0000;
        input_OperandB  = 16'h0000;
        input_RespReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_reqready", 32'(output_ReqReady), 32'd1);
        check("rst_respvalid", 32'(output_RespValid), 32'd0);
        check("rst_busy", 32'(output_Busy), 32'd0);
        check("rst_aluop", 32'(output_ALUOp), 32'h000C);
        check("rst_alu_ab", {output_ALU_A, output_ALU_B}, 32'd0);
        check("rst_result", {12'd0, output_Error, output_Flags, output_Result}, 32'd0);
        @(negedge clk);
        input_Reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: the response must hold while RespReady is low, and
        // new requests must be ignored.
        input_RespReady = 1'b0;
        input_Opcode    = 4'b0000;
        input_OperandA  = 16'h1111;
        input_OperandB  = 16'h2222;
        input_ReqValid  = 1'b1;
        @(posedge clk); #1;
        input_Opcode    = 4'b0001;            // competing request stays asserted
        input_OperandA  = 16'h0001;
        input_OperandB  = 16'h0002;
        @(posedge clk); #1;
        check("bp_respvalid", 32'(output_RespValid), 32'd1);
        held_result = output_Result;
        check("bp_result", 32'(held_result), 32'h3333);
        stable_ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (!(output_RespValid && !output_ReqReady && output_Result == 16'h3333 &&
                  output_Flags == 3'b000 && !output_Error)) stable_ok = 0;
        end
        check("bp_stable_5cyc", 32'(stable_ok), 32'd1);
        input_ReqValid  = 1'b0;
        input_RespReady = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", {30'd0, output_ReqReady, output_Busy}, 32'b10);
        $display("backpressure: result=%h held 5 cycles, returned to idle", held_result);
        @(posedge clk); #1;
        check("bp_no_stray_accept", 32'(output_Busy), 32'd0);

        // Reset in EXEC drops the op.
        input_Opcode   = 4'b0000;
        input_OperandA = 16'h0100;
        input_OperandB = 16'h0200;
        input_ReqValid = 1'b1;
        @(posedge clk); #1;
        input_ReqValid = 1'b0;
        check("exec_busy", 32'(output_Busy), 32'd1);
        input_Reset = 1'b1;
        #1;
        check("rstexec_aluop", 32'(output_ALUOp), 32'h000C);
        check("rstexec_alu_ab", {output_ALU_A, output_ALU_B}, 32'd0);
        check("rstexec_ctrl", {29'd0, output_ReqReady, output_RespValid, output_Busy}, 32'b100);
        check("rstexec_result", {12'd0, output_Error, output_Flags, output_Result}, 32'd0);
        @(negedge clk);
        input_Reset = 1'b0;
        stable_ok = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (output_RespValid || output_Busy) stable_ok = 0;
        end
        check("rstexec_no_resp", 32'(stable_ok), 32'd1);
        $display("reset during exec: op dropped, no response");

        // The DUT must work normally after the mid-op reset.
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
